waveform_generator: RTL and testbench
=====================================

WAVEFORM_GENERATOR -- requirements
Module: waveform_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 8: sample width of wave_out and phase register.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: width of runtime prescale divisor.
REQ-003 SHALL have parameter DEFAULT_DIV, default 256: prescale ratio after reset, 1..2^DIV_WIDTH.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rstn  input  1: asynchronous active-low reset.
REQ-006 SHALL have port en  input  1: run enable; low freezes all state except config capture.
REQ-007 SHALL have port cfg_load  input  1: one-cycle strobe capturing mode/div/step and restarting the waveform.
REQ-008 SHALL have port mode  input  2: 0 saw-up, 1 saw-down, 2 triangle, 3 square.
REQ-009 SHALL have port div  input  DIV_WIDTH: prescale; one tick every div+1 enabled cycles.
REQ-010 SHALL have port step  input  WIDTH: phase increment per tick.
REQ-011 SHALL have port wave_out  output  WIDTH: registered waveform sample.
REQ-012 SHALL have port tick  output  1: registered one-cycle pulse, high in the cycle wave_out shows a new sample.
REQ-013 SHALL have port wrap  output  1: registered one-cycle pulse marking period boundary, coincident with tick.

Function
REQ-014 Prescaler SHALL count 0..div_q while en=1; at div_q it returns to 0 and issues an internal tick; en=0 holds count.
REQ-015 div_q=0 SHALL tick every enabled cycle.
REQ-016 On each internal tick the phase register and wave_out SHALL update on that edge; tick output high for the following cycle (latency 1 from prescaler terminal count).
REQ-017 Saw-up: phase <= phase+step modulo 2^WIDTH; wrap when the WIDTH+1-bit sum carries.
REQ-018 Saw-down: phase <= phase-step modulo 2^WIDTH; wrap on borrow.
REQ-019 Triangle: direction bit dir; dir up and phase+step >= 2^WIDTH-1 -> phase <= 2^WIDTH-1, dir <= down; dir down and phase <= step -> phase <= 0, dir <= up, wrap; otherwise phase +/- step.
REQ-020 Square: phase advances as saw-up; wave_out = all ones when phase MSB=0, else 0; wrap on carry.
REQ-021 Saw/triangle: wave_out SHALL equal new phase value.
REQ-022 step_q=0 SHALL hold phase and never assert wrap; tick still pulses.
REQ-023 cfg_load=1 SHALL, on that edge: capture mode/div/step into mode_q/div_q/step_q, clear prescaler, phase, dir(up), wave_out, tick, wrap; independent of en.
REQ-024 cfg_load coinciding with a prescaler terminal count: cfg_load wins, no tick or wrap issued.
REQ-025 Config inputs SHALL be ignored except when cfg_load=1.

Reset
REQ-026 rstn low SHALL asynchronously force wave_out=0, tick=0, wrap=0, phase=0, dir=up, prescaler=0.
REQ-027 Reset SHALL set mode_q=0, div_q=DEFAULT_DIV-1, step_q=1 (sawtooth incrementing by 1 every DEFAULT_DIV cycles).
REQ-028 Reset asserted mid-period SHALL discard in-flight count; first tick after release occurs DEFAULT_DIV enabled cycles later.

Structure
REQ-029 Package waveform_pkg SHALL hold the mode encoding (MODE_SAW_UP, MODE_SAW_DN, MODE_TRI, MODE_SQUARE) and direction constants.
REQ-030 Prescaler SHALL be a sub-module tick_divider (clk, rstn, en, clr, div, tick).

Verification
REQ-031 Reset defaults, en=1, 600 cycles -> wave_out 0,1,2 with ticks on cycles 256, 512; no wrap.
REQ-032 cfg_load mode=0, div=0, step=64, WIDTH=8 -> wave_out 64,128,192,0; wrap on 4th tick only.
REQ-033 cfg_load mode=2, div=1, step=100 -> 100,200,255(dir down),155,55,0(wrap),100; ticks every 2 cycles.
REQ-034 cfg_load mode=3, div=0, step=64 -> 255,0,0,255 (phase 64,128,192,0); wrap with 4th sample.
REQ-035 mode=1, step=3, en dropped 5 cycles mid-run, then cfg_load asserted on a terminal-count cycle -> values frozen during en=0; after cfg_load wave_out=0, no tick that cycle.
REQ-036 rstn pulsed low asynchronously between clock edges mid-triangle -> all outputs 0 immediately, defaults restored per REQ-027.

Source files
------------

// File: rtl/waveform_pkg.sv
// waveform_pkg: shared encodings for waveform_generator.
//   mode_e  - waveform selection as presented on the 2-bit mode port
//   DIR_*   - triangle direction bit values
package waveform_pkg;

    typedef enum logic [1:0] {
        MODE_SAW_UP = 2'd0,
        MODE_SAW_DN = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SQUARE = 2'd3
    } mode_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/waveform_generator_tick_divider.sv
// tick_divider: programmable prescaler for waveform_generator.
//   clk, rstn - clock, asynchronous active-low reset
//   en        - count enable; low holds the count
//   clr       - synchronous clear, overrides en and suppresses tick
//   div       - terminal count; one tick every div+1 enabled cycles
//   tick      - combinational, high in the cycle the count sits at div
//               while enabled (consumed on the following edge)
module tick_divider #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count_q;
    logic [DIV_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == div) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/waveform_generator.sv
// waveform_generator: prescaled phase accumulator producing saw-up,
// saw-down, triangle or square samples.
//   clk, rstn      - clock, asynchronous active-low reset
//   en             - run enable; low freezes phase and prescaler
//   cfg_load       - strobe: capture mode/div/step and restart the waveform
//   mode, div, step- configuration, sampled only with cfg_load
//   wave_out       - registered sample
//   tick           - one-cycle pulse with each new sample
//   wrap           - one-cycle pulse at the period boundary (with tick)
module waveform_generator
    import waveform_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEFAULT_DIV = 256
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 cfg_load,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [WIDTH-1:0]     step,
    output logic [WIDTH-1:0]     wave_out,
    output logic                 tick,
    output logic                 wrap
);

    localparam logic [DIV_WIDTH-1:0] DIV_RST   = DIV_WIDTH'(DEFAULT_DIV - 1);
    localparam logic [WIDTH-1:0]     STEP_RST  = WIDTH'(1);
    localparam logic [WIDTH-1:0]     PHASE_MAX = '1;

    mode_e                mode_q,  mode_d;
    logic [DIV_WIDTH-1:0] div_q,   div_d;
    logic [WIDTH-1:0]     step_q,  step_d;
    logic [WIDTH-1:0]     phase_q, phase_d;
    logic                 dir_q,   dir_d;
    logic [WIDTH-1:0]     wave_q,  wave_d;
    logic                 tick_q,  tick_d;
    logic                 wrap_q,  wrap_d;

    logic                 div_tick;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;

    tick_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_divider (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .clr  (cfg_load),
        .div  (div_q),
        .tick (div_tick)
    );

    // Extra MSB of sum/diff is the carry/borrow that marks a wrap.
    assign sum  = {1'b0, phase_q} + {1'b0, step_q};
    assign diff = {1'b0, phase_q} - {1'b0, step_q};

    always_comb begin
        mode_d  = mode_q;
        div_d   = div_q;
        step_d  = step_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        wave_d  = wave_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (cfg_load) begin
            // cfg_load has priority over a coincident prescaler tick.
            mode_d  = mode_e'(mode);
            div_d   = div;
            step_d  = step;
            phase_d = '0;
            dir_d   = DIR_UP;
            wave_d  = '0;
        end else if (div_tick) begin
            tick_d = 1'b1;
            case (mode_q)
                MODE_SAW_UP, MODE_SQUARE: begin
                    phase_d = sum[WIDTH-1:0];
                    wrap_d  = sum[WIDTH];
                end
                MODE_SAW_DN: begin
                    phase_d = diff[WIDTH-1:0];
                    wrap_d  = diff[WIDTH];
                end
                MODE_TRI: begin
                    if (dir_q == DIR_UP) begin
                        if (sum >= {1'b0, PHASE_MAX}) begin
                            phase_d = PHASE_MAX;
                            dir_d   = DIR_DN;
                        end else begin
                            phase_d = sum[WIDTH-1:0];
                        end
                    end else if (phase_q <= step_q) begin
                        phase_d = '0;
                        dir_d   = DIR_UP;
                        wrap_d  = 1'b1;
                    end else begin
                        phase_d = diff[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
            // Square output is high for the first half of the phase range.
            if (mode_q == MODE_SQUARE) begin
                wave_d = {WIDTH{~phase_d[WIDTH-1]}};
            end else begin
                wave_d = phase_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q  <= MODE_SAW_UP;
            div_q   <= DIV_RST;
            step_q  <= STEP_RST;
            phase_q <= '0;
            dir_q   <= DIR_UP;
            wave_q  <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            div_q   <= div_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            wave_q  <= wave_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign wave_out = wave_q;
    assign tick     = tick_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Bench for waveform_generator (WIDTH=8, DIV_WIDTH=16, DEFAULT_DIV=256).
// The driver keeps an arithmetic model of the generator and pushes the
// expected outputs for each cycle that should change them; the monitor
// checks every cycle against the queue head or against the held sample.
module tb_waveform_generator;

    localparam int MAXV = 255;

    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        en       = 1'b0;
    logic        cfg_load = 1'b0;
    logic [1:0]  mode     = 2'd0;
    logic [15:0] div      = 16'd0;
    logic [7:0]  step     = 8'd0;
    logic [7:0]  wave_out;
    logic        tick;
    logic        wrap;

    waveform_generator #(
        .WIDTH       (8),
        .DIV_WIDTH   (16),
        .DEFAULT_DIV (256)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .cfg_load (cfg_load),
        .mode     (mode),
        .div      (div),
        .step     (step),
        .wave_out (wave_out),
        .tick     (tick),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit tk;
        int wave;
        bit wr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_mode, m_div, m_step, m_cnt, m_ph;
    bit m_up;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_div  = 255;
        m_step = 1;
        m_cnt  = 0;
        m_ph   = 0;
        m_up   = 1'b1;
    endtask

    // Apply inputs for one cycle, predict the result of the next edge.
    task automatic drive(input bit e, input bit c, input int md, input int dv, input int st);
        exp_t x;
        int   s;
        bit   wr;
        int   wv;
        en       = e;
        cfg_load = c;
        mode     = md[1:0];
        div      = dv[15:0];
        step     = st[7:0];
        if (c) begin
            m_mode = md;
            m_div  = dv;
            m_step = st;
            m_cnt  = 0;
            m_ph   = 0;
            m_up   = 1'b1;
            x = '{cyc + 1, 1'b0, 0, 1'b0};
            q.push_back(x);
        end else if (e) begin
            m_cnt++;
            if (m_cnt == m_div + 1) begin
                m_cnt = 0;
                wr    = 1'b0;
                case (m_mode)
                    1: begin
                        s    = m_ph - m_step;
                        wr   = (s < 0);
                        m_ph = (s + MAXV + 1) % (MAXV + 1);
                    end
                    2: begin
                        if (m_up) begin
                            if (m_ph + m_step >= MAXV) begin
                                m_ph = MAXV;
                                m_up = 1'b0;
                            end else begin
                                m_ph = m_ph + m_step;
                            end
                        end else if (m_ph <= m_step) begin
                            m_ph = 0;
                            m_up = 1'b1;
                            wr   = 1'b1;
                        end else begin
                            m_ph = m_ph - m_step;
                        end
                    end
                    default: begin
                        s    = m_ph + m_step;
                        wr   = (s > MAXV);
                        m_ph = s % (MAXV + 1);
                    end
                endcase
                wv = (m_mode == 3) ? ((m_ph < 128) ? MAXV : 0) : m_ph;
                x = '{cyc + 1, 1'b1, wv, wr};
                q.push_back(x);
            end
        end
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    // Monitor: one check set per cycle, away from the active edge.
    int held = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("stale_expectation", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check("tick", int'(tick), int'(e.tk));
                check("wave_out", int'(wave_out), e.wave);
                check("wrap", int'(wrap), int'(e.wr));
                held = e.wave;
            end else begin
                check("tick_idle", int'(tick), 0);
                check("wave_hold", int'(wave_out), held);
                check("wrap_idle", int'(wrap), 0);
            end
        end
    end

    initial begin
        exp_t x;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_wave", int'(wave_out), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_wrap", int'(wrap), 0);
        rstn = 1'b1;

        // Defaults: saw-up by 1 every 256 cycles
        repeat (600) drive(1, 0, 0, 0, 0);

        // Saw-up, step 64, tick every cycle
        drive(1, 1, 0, 0, 64);
        repeat (6) drive(1, 0, 0, 0, 0);

        // Triangle, step 100, tick every 2 cycles
        drive(1, 1, 2, 1, 100);
        repeat (16) drive(1, 0, 0, 0, 0);

        // Square, step 64
        drive(1, 1, 3, 0, 64);
        repeat (6) drive(1, 0, 0, 0, 0);

        // Saw-down with en gap, then cfg_load on a terminal-count cycle
        drive(1, 1, 1, 2, 3);
        repeat (7) drive(1, 0, 0, 0, 0);
        repeat (5) drive(0, 0, 3, 9, 77);
        for (int i = 0; i < 10 && m_cnt != m_div; i++) drive(1, 0, 0, 0, 0);
        check("terminal_count_reached", m_cnt, m_div);
        drive(1, 1, 1, 2, 3);
        repeat (8) drive(1, 0, 0, 0, 0);

        // Asynchronous reset between edges in the middle of a triangle
        drive(1, 1, 2, 0, 40);
        repeat (10) drive(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("async_reset_wave", int'(wave_out), 0);
        check("async_reset_tick", int'(tick), 0);
        check("async_reset_wrap", int'(wrap), 0);
        model_reset();
        q.delete();
        x = '{cyc + 1, 1'b0, 0, 1'b0};
        q.push_back(x);
        #1;
        rstn = 1'b1;
        repeat (300) drive(1, 0, 0, 0, 0);

        // Randomized run; config inputs toggle freely without cfg_load
        drive(1, 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 255));
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 49) == 0,
                  $urandom_range(0, 3),
                  $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255));
        end

        repeat (2) drive(0, 0, 0, 0, 0);
        check("queue_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
